sbox_affine_stage: RTL

Buffered GF(2)-affine transform stage for the byte-substitution datapath. Forward mode consumes the GF(2^8) inverter's output and produces the AES S-box value. Inverse mode applies the inverse affine map, producing the byte that feeds the inverter for the inverse S-box. A 2-entry valid/ready buffer decouples the combinational inverter from downstream round logic and sustains one byte per cycle.

---
 rtl/sbox_affine_stage.sv | 96 +++++++++
 1 files changed

// File: rtl/sbox_affine_stage.sv
// GF(2)-affine stage of the AES byte-substitution path (forward and inverse maps),
// followed by a 2-entry valid/ready buffer whose head register drives the outputs.
module sbox_affine_stage #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_byte,
    input  logic               in_dir,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_byte,
    output logic               out_dir,
    output logic [COUNT_W-1:0] byte_count
);

    localparam logic [7:0] FWD_C = 8'h63;
    localparam logic [7:0] INV_D = 8'h05;

    logic [7:0] fwd_b;
    logic [7:0] inv_b;
    logic [8:0] new_entry;

    for (genvar gi = 0; gi < 8; gi++) begin : g_affine
        assign fwd_b[gi] = in_byte[gi] ^ in_byte[(gi + 4) % 8] ^ in_byte[(gi + 5) % 8]
                         ^ in_byte[(gi + 6) % 8] ^ in_byte[(gi + 7) % 8] ^ FWD_C[gi];
        assign inv_b[gi] = in_byte[(gi + 2) % 8] ^ in_byte[(gi + 5) % 8]
                         ^ in_byte[(gi + 7) % 8] ^ INV_D[gi];
    end

    assign new_entry = {in_dir, (in_dir ? inv_b : fwd_b)};

    logic [1:0]         occ_q, occ_d;
    logic [8:0]         head_q, head_d;
    logic [8:0]         tail_q, tail_d;
    logic               in_ready_q, in_ready_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               push;
    logic               pop;

    assign push = in_valid && in_ready_q;
    assign pop  = (occ_q != 2'd0) && out_ready;

    // Head is always the oldest entry; tail only holds the second entry when full.
    always_comb begin
        occ_d   = occ_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push && !pop) begin
            occ_d = occ_q + 2'd1;
        end else if (pop && !push) begin
            occ_d = occ_q - 2'd1;
        end
        if (pop) begin
            count_d = count_q + 1'b1;
            if (occ_q == 2'd2) begin
                head_d = tail_q;
            end else if (push) begin
                head_d = new_entry;
            end
        end else if (push) begin
            if (occ_q == 2'd0) begin
                head_d = new_entry;
            end else begin
                tail_d = new_entry;
            end
        end
        in_ready_d = (occ_d < 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q      <= 2'd0;
            head_q     <= 9'd0;
            tail_q     <= 9'd0;
            in_ready_q <= 1'b0;
            count_q    <= '0;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
            count_q    <= count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (occ_q != 2'd0);
    assign out_byte   = head_q[7:0];
    assign out_dir    = head_q[8];
    assign byte_count = count_q;

endmodule
